// File: rtl/dout_emulator.sv
// AD7771 DOUT-interface transmitter: drives /DRDY, DCLK and DOUT as master, 64-bit frames MSB first.
// Optional DOUT_TEST_PATTERN_EN replaces the channel fields with a frame counter and its complement.
module dout_emulator #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned FRAME_PERIOD = 600
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [7:0]  hdr1_i,
  input  logic [23:0] ch1_i,
  input  logic [7:0]  hdr2_i,
  input  logic [23:0] ch2_i,
  output logic        drdy_o,
  output logic        dclk_o,
  output logic        dout_o,
  output logic        load_o,
  output logic        tick_o,
  output logic        busy_o
);

  localparam int unsigned TimerW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int unsigned DivW   = $clog2(CLK_DIV + 1);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("dout_emulator: CLK_DIV must be >= 4");
  end

  if (FRAME_PERIOD < (2 * 64 + 1) * CLK_DIV + 2) begin : g_bad_frame_period
    $error("dout_emulator: FRAME_PERIOD too short for a 64-bit frame at this CLK_DIV");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StClkLo,
    StClkHi,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [6:0]          bit_q, bit_d;
  // Bit 63 goes straight onto DOUT at the latch, so only the remaining 63 bits are held here.
  logic [62:0]         sreg_q, sreg_d;
  logic                drdy_q, drdy_d;
  logic                dclk_q, dclk_d;
  logic                dout_q, dout_d;
  logic                load_q, load_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;

  logic [63:0]         frame;
  logic                latch;
  logic                div_end;

`ifdef DOUT_TEST_PATTERN_EN
  logic [23:0] cnt_q;
  logic        unused_ch;

  assign unused_ch = ^{ch1_i, ch2_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (latch) begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  assign frame = {hdr1_i, cnt_q, hdr2_i, ~cnt_q};
`else
  assign frame = {hdr1_i, ch1_i, hdr2_i, ch2_i};
`endif

  // Timer free-runs while enabled so /DRDY falls stay exactly FRAME_PERIOD apart.
  always_comb begin
    timer_d = '0;
    if (en_i) begin
      if (timer_q == TimerW'(FRAME_PERIOD - 1)) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  assign latch   = (state_q == StIdle) && en_i && (timer_q == '0);
  assign div_end = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    drdy_d  = drdy_q;
    dclk_d  = dclk_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    load_d  = 1'b0;
    tick_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (latch) begin
          sreg_d  = frame[62:0];
          dout_d  = frame[63];
          load_d  = 1'b1;
          drdy_d  = 1'b0;
          dclk_d  = 1'b1;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = StSetup;
        end
      end

      StSetup: begin
        if (div_end) begin
          div_d   = '0;
          dclk_d  = 1'b0;
          state_d = StClkLo;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StClkLo: begin
        if (div_end) begin
          div_d   = '0;
          dclk_d  = 1'b1;
          state_d = StClkHi;
          bit_d   = bit_q + 7'd1;
          // bit_q counts completed DCLK falls minus one; the 64th rising edge only emits tick.
          if (bit_q < 7'd63) begin
            dout_d = sreg_q[62];
            sreg_d = {sreg_q[61:0], 1'b0};
          end else begin
            tick_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StClkHi: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == 7'd64) begin
            state_d = StDone;
          end else begin
            dclk_d  = 1'b0;
            state_d = StClkLo;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StDone: begin
        drdy_d  = 1'b1;
        dout_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      drdy_q  <= 1'b1;
      dclk_q  <= 1'b1;
      dout_q  <= 1'b0;
      load_q  <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      drdy_q  <= drdy_d;
      dclk_q  <= dclk_d;
      dout_q  <= dout_d;
      load_q  <= load_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign drdy_o = drdy_q;
  assign dclk_o = dclk_q;
  assign dout_o = dout_q;
  assign load_o = load_q;
  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_dout_emulator.sv
// Bench for dout_emulator: receiver model samples DOUT on DCLK falls and checks each frame,
// /DRDY spacing, DOUT setup/hold, tick/load pulses, enable drop and mid-frame reset.
module tb_dout_emulator;

  localparam int CLK_DIV = 4;
  localparam int FP      = 600;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  hdr1, hdr2;
  logic [23:0] ch1, ch2;
  logic        drdy, dclk, dout, load, tick, busy;

  dout_emulator #(
    .CLK_DIV      (CLK_DIV),
    .FRAME_PERIOD (FP)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .en_i    (en),
    .hdr1_i  (hdr1),
    .ch1_i   (ch1),
    .hdr2_i  (hdr2),
    .ch2_i   (ch2),
    .drdy_o  (drdy),
    .dclk_o  (dclk),
    .dout_o  (dout),
    .load_o  (load),
    .tick_o  (tick),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Receiver / reference model state
  int          cyc = 0;
  int          last_fall_cyc = -1;
  int          since_chg = 100;
  int          hold_left = 0;
  logic        hold_val = 1'b0;
  logic        prev_drdy = 1'b1;
  logic        prev_dclk = 1'b1;
  logic        prev_dout = 1'b0;
  logic [63:0] rx = '0;
  logic [63:0] last_rx = '0;
  logic [63:0] exp_frame = '0;
  int          rx_falls = 0;
  int          rx_ticks = 0;
  logic        in_frame = 1'b0;
  int          n_starts = 0;
  int          n_done = 0;
`ifdef DOUT_TEST_PATTERN_EN
  logic [23:0] tp_cnt = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_frame();
`ifdef DOUT_TEST_PATTERN_EN
    return {hdr1, tp_cnt, hdr2, ~tp_cnt};
`else
    return {hdr1, ch1, hdr2, ch2};
`endif
  endfunction

  task automatic rand_inputs();
    hdr1 = 8'($urandom);
    ch1  = 24'($urandom);
    hdr2 = 8'($urandom);
    ch2  = 24'($urandom);
  endtask

  task automatic model_reset();
    prev_drdy     = 1'b1;
    prev_dclk     = 1'b1;
    prev_dout     = 1'b0;
    since_chg     = 100;
    hold_left     = 0;
    in_frame      = 1'b0;
    last_fall_cyc = -1;
`ifdef DOUT_TEST_PATTERN_EN
    tp_cnt        = '0;
`endif
  endtask

  // One clock: wait for the falling edge and run the receiver model on the settled outputs.
  task automatic cycle();
    logic fell_drdy, rose_drdy, fell_dclk;
    @(negedge clk);
    cyc++;
    fell_drdy = prev_drdy && !drdy;
    rose_drdy = !prev_drdy && drdy;
    fell_dclk = prev_dclk && !dclk;
    since_chg = (dout === prev_dout) ? since_chg + 1 : 0;

    chk("busy_vs_drdy", 64'(busy), 64'(!drdy));
    chk("load_pulse", 64'(load), 64'(fell_drdy));

    if (fell_drdy) begin
      if (last_fall_cyc >= 0) chk("drdy_period", 64'(cyc - last_fall_cyc), 64'(FP));
      last_fall_cyc = cyc;
      exp_frame = model_frame();
`ifdef DOUT_TEST_PATTERN_EN
      tp_cnt = tp_cnt + 24'd1;
`endif
      rx       = '0;
      rx_falls = 0;
      rx_ticks = 0;
      in_frame = 1'b1;
      n_starts++;
    end

    if (fell_dclk) begin
      chk("fall_in_frame", 64'(in_frame), 64'd1);
      chk("dout_setup", 64'(since_chg >= CLK_DIV), 64'd1);
      rx = {rx[62:0], dout};
      rx_falls++;
      hold_left = CLK_DIV - 1;
      hold_val  = dout;
    end else if (hold_left > 0) begin
      chk("dout_hold", 64'(dout), 64'(hold_val));
      hold_left--;
    end

    if (tick) begin
      rx_ticks++;
      chk("tick_after_64_falls", 64'(rx_falls), 64'd64);
      chk("tick_dclk_high", 64'(dclk), 64'd1);
    end

    if (rose_drdy && in_frame) begin
      chk("frame_data", rx, exp_frame);
      chk("dclk_falls", 64'(rx_falls), 64'd64);
      chk("tick_count", 64'(rx_ticks), 64'd1);
      chk("dclk_idle_high", 64'(dclk), 64'd1);
      in_frame = 1'b0;
      last_rx  = rx;
      n_done++;
    end

    prev_drdy = drdy;
    prev_dclk = dclk;
    prev_dout = dout;
  endtask

  task automatic wait_frame(input int budget);
    int target;
    target = n_done + 1;
    for (int i = 0; i < budget && n_done < target; i++) cycle();
    chk("frame_timeout", 64'(n_done), 64'(target));
  endtask

  task automatic wait_falls(input int k, input int budget);
    for (int i = 0; i < budget && !(in_frame && rx_falls >= k); i++) cycle();
    chk("falls_timeout", 64'(in_frame && rx_falls >= k), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_drdy"}, 64'(drdy), 64'd1);
    chk({tag, "_dclk"}, 64'(dclk), 64'd1);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
    chk({tag, "_load"}, 64'(load), 64'd0);
    chk({tag, "_tick"}, 64'(tick), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int target;
    int starts0;
    rst  = 1'b1;
    en   = 1'b0;
    hdr1 = '0;
    ch1  = '0;
    hdr2 = '0;
    ch2  = '0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed frame
    hdr1 = 8'h80;
    ch1  = 24'h123456;
    hdr2 = 8'h81;
    ch2  = 24'hABCDEF;
    en   = 1'b1;
    wait_frame(FP + 100);
`ifndef DOUT_TEST_PATTERN_EN
    chk("directed_frame", last_rx, 64'h80123456_81ABCDEF);
`endif

    // Free-run with random input changes, including a ch1 change inside every frame
    target = n_done + 5;
    for (int i = 0; i < 6 * FP && n_done < target; i++) begin
      cycle();
      if (in_frame && rx_falls == 30 && hold_left == CLK_DIV - 1) ch1 = 24'($urandom);
      if ($urandom_range(0, 49) == 0) rand_inputs();
    end
    chk("freerun_frames", 64'(n_done), 64'(target));

    // Drop enable after bit 20: frame finishes, then silence
    wait_falls(20, FP + 100);
    en = 1'b0;
    last_fall_cyc = -1;
    wait_frame(FP + 100);
    starts0 = n_starts;
    repeat (2 * FP) cycle();
    chk("no_drdy_after_disable", 64'(n_starts), 64'(starts0));
    chk("drdy_high_disabled", 64'(drdy), 64'd1);

    // Reset at bit 40 aborts the frame at once
    rand_inputs();
    en = 1'b1;
    wait_falls(40, FP + 100);
    rst = 1'b1;
    #1;
    check_idle_outputs("midframe_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_tick", 64'(tick), 64'd0);
      chk("reset_drdy", 64'(drdy), 64'd1);
    end
    rst = 1'b0;
    model_reset();
    rand_inputs();
    wait_frame(FP + 100);
    wait_frame(FP + 100);

`ifdef DOUT_TEST_PATTERN_EN
    // Counter pattern from a clean reset: ch1 = 0,1,2 and ch2 = ~ch1
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_inputs();
      wait_frame(FP + 100);
      chk("tp_ch1", 64'(last_rx[55:32]), 64'(f));
      chk("tp_ch2", 64'(last_rx[23:0]), 64'(24'hFFFFFF - 24'(f)));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
